double_to_int: RTL

DOUBLE_TO_INT -- requirements
Module: double_to_int

---
 rtl/double_to_int.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/double_to_int.sv
// IEEE-754 binary64 to int64 converter: round-half-even, saturating, two register stages with valid/ready flow control.
// Define DOUBLE_TO_INT_FLAGS_EN to add result_tuser[1:0] = {invalid, inexact}.

module double_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_tvalid,
  input  logic [63:0] a_tdata,
  output logic        a_tready,
  output logic        result_tvalid,
  output logic [63:0] result_tdata,
  input  logic        result_tready
`ifdef DOUBLE_TO_INT_FLAGS_EN
  ,
  output logic [1:0]  result_tuser
`endif
);

  localparam int DATA_W = 64;
  localparam int MAN_W  = 52;
  localparam int INT_W  = 63;
  localparam int ALN_W  = INT_W + 1 + MAN_W;

  localparam logic [10:0] EXP_HALF = 11'd1022;
  localparam logic [10:0] EXP_SAT  = 11'd1086;
  localparam logic [10:0] EXP_MAX  = 11'h7FF;

  localparam logic signed [DATA_W-1:0] INT_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [DATA_W-1:0] INT_MIN = 64'sh8000_0000_0000_0000;

  function automatic logic [DATA_W-1:0] round_rne(input logic [INT_W-1:0] mag,
                                                  input logic rnd,
                                                  input logic stk);
    logic up;
    up = rnd & (stk | mag[0]);
    return {1'b0, mag} + {{(DATA_W-1){1'b0}}, up};
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic ovf,
                                                       input logic ovf_neg,
                                                       input logic sgn,
                                                       input logic [DATA_W-1:0] mag);
    logic signed [DATA_W-1:0] smag;
    smag = signed'(mag);
    if (ovf) return ovf_neg ? INT_MIN : INT_MAX;
    return sgn ? -smag : smag;
  endfunction

  logic advance;
  logic vld_p1, vld_p2;

  logic              sgn_p0, nan_p0, ovf_p0, ovf_neg_p0, rnd_p0, stk_p0;
  logic [10:0]       exp_p0;
  logic [MAN_W-1:0]  man_p0;
  logic [ALN_W-1:0]  aln_p0;
  logic [INT_W-1:0]  int_p0;

  logic              sgn_p1, ovf_p1, ovf_neg_p1, rnd_p1, stk_p1;
  logic [INT_W-1:0]  int_p1;

  logic signed [DATA_W-1:0] res_p2;

  assign advance       = ~vld_p2 | result_tready;
  assign a_tready      = advance;
  assign result_tvalid = vld_p2;
  assign result_tdata  = res_p2;

  // Stage 1 input: decode, classify, align to integer / round bit / sticky
  always_comb begin
    sgn_p0     = a_tdata[63];
    exp_p0     = a_tdata[62:52];
    man_p0     = a_tdata[51:0];
    nan_p0     = (exp_p0 == EXP_MAX) && (man_p0 != '0);
    ovf_p0     = exp_p0 >= EXP_SAT;
    ovf_neg_p0 = sgn_p0 | nan_p0;
    aln_p0     = {{INT_W{1'b0}}, 1'b1, man_p0} << (exp_p0 - EXP_HALF);
    int_p0     = '0;
    rnd_p0     = 1'b0;
    stk_p0     = 1'b0;
    if (ovf_p0) begin
      int_p0 = '0;
    end else if (exp_p0 < EXP_HALF) begin
      // Below 0.5 in magnitude: always rounds to zero, inexact unless exactly zero.
      stk_p0 = |a_tdata[62:0];
    end else begin
      int_p0 = aln_p0[ALN_W-1:MAN_W+1];
      rnd_p0 = aln_p0[MAN_W];
      stk_p0 = |aln_p0[MAN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= a_tvalid;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && a_tvalid) begin
      sgn_p1     <= sgn_p0;
      ovf_p1     <= ovf_p0;
      ovf_neg_p1 <= ovf_neg_p0;
      int_p1     <= int_p0;
      rnd_p1     <= rnd_p0;
      stk_p1     <= stk_p0;
    end
  end

  // Stage 2: round, negate, saturate; cleared in reset so the output reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p2 <= '0;
    end else if (advance && vld_p1) begin
      res_p2 <= saturate(ovf_p1, ovf_neg_p1, sgn_p1, round_rne(int_p1, rnd_p1, stk_p1));
    end
  end

`ifdef DOUBLE_TO_INT_FLAGS_EN
  logic       inv_p0, inv_p1;
  logic [1:0] flg_p2;

  // Only -2^63 saturates exactly; every other overflow, Inf and NaN is invalid.
  assign inv_p0 = ovf_p0 & ~(sgn_p0 & (exp_p0 == EXP_SAT) & (man_p0 == '0));

  always_ff @(posedge clk) begin
    if (advance && a_tvalid) inv_p1 <= inv_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_p2 <= '0;
    end else if (advance && vld_p1) begin
      flg_p2 <= {inv_p1, ~inv_p1 & (rnd_p1 | stk_p1)};
    end
  end

  assign result_tuser = flg_p2;
`endif

endmodule
